alu_mc: RTL and testbench

- Parametrised, multi-cycle ALU for the ARM-style datapath; successor to the single-cycle combinational ALU.
- Adds a valid/ready handshake, a registered NZCV flag register, XOR, and an iterative shift-add multiply.
- An optional restoring divide is compiled in by macro.
- Sits between register-read and writeback; the execute stage stalls on in_ready/out_valid.

---
 rtl/alu_mc_pkg.sv | 27 ++
 rtl/alu_mc_iter.sv | 99 +++++++++
 rtl/alu_mc.sv | 158 +++++++++++++++
 tb/tb_alu_mc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, FSM states and flag bit positions shared by the alu_mc block.
package alu_mc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_MUL = 3'b110,
      OP_DIV = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit positions inside the {N,Z,C,V} flag register
   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_C = 1;
   localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative shift-add multiplier (one operand bit per cycle).
// With ALU_MC_DIV_EN defined it also hosts an unsigned restoring divider.
// The first step is taken on the start cycle itself, so WIDTH steps finish
// one cycle before the owner's counter reaches zero.
module alu_mc_iter
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef ALU_MC_DIV_EN
   input  logic             is_div,
`endif
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] acc
);

   logic             busy_q, done_q;
   logic [WIDTH-1:0] acc_q, opa_q, opb_q;
   logic [WIDTH-1:0] src_acc, src_opa, src_opb;
   logic [WIDTH-1:0] nxt_acc, nxt_opa, nxt_opb;
`ifdef ALU_MC_DIV_EN
   logic             div_q, src_div;
   logic [WIDTH-1:0] rem_q, src_rem, nxt_rem;
   logic [WIDTH:0]   rem_sh, trial;
`endif

   // One step, sourced from the fresh operands on start or from held state
   always_comb begin
      src_acc = start ? '0 : acc_q;
      src_opa = start ? a  : opa_q;
      src_opb = start ? b  : opb_q;
      nxt_acc = src_opb[0] ? src_acc + src_opa : src_acc;
      nxt_opa = src_opa << 1;
      nxt_opb = src_opb >> 1;
`ifdef ALU_MC_DIV_EN
      src_div = start ? is_div : div_q;
      src_rem = start ? '0 : rem_q;
      // opa doubles as dividend (shifting out) and quotient (shifting in)
      rem_sh  = {src_rem, src_opa[WIDTH-1]};
      trial   = rem_sh - {1'b0, src_opb};
      nxt_rem = src_rem;
      if (src_div) begin
         nxt_acc = src_acc;
         nxt_opb = src_opb;
         if (!trial[WIDTH]) begin
            nxt_rem = trial[WIDTH-1:0];
            nxt_opa = {src_opa[WIDTH-2:0], 1'b1};
         end else begin
            nxt_rem = rem_sh[WIDTH-1:0];
            nxt_opa = {src_opa[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // Step registers; done pulses for one cycle after the last step
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         acc_q  <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
`ifdef ALU_MC_DIV_EN
         div_q  <= 1'b0;
         rem_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (start || busy_q) begin
            acc_q  <= nxt_acc;
            opa_q  <= nxt_opa;
            opb_q  <= nxt_opb;
`ifdef ALU_MC_DIV_EN
            div_q  <= src_div;
            rem_q  <= nxt_rem;
`endif
            busy_q <= !last;
            done_q <= last;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
`ifdef ALU_MC_DIV_EN
   assign acc  = div_q ? opa_q : acc_q;
`else
   assign acc  = acc_q;
`endif

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered NZCV flags.
// Optional feature: define ALU_MC_DIV_EN to make op 111 an unsigned divide.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int unsigned MSB = WIDTH - 1;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic             iter_op, iter_start, iter_last, iter_busy, iter_done;
   logic [WIDTH-1:0] iter_acc;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH:0]   sum;
   logic             sc_c, sc_v;
   logic [3:0]       sc_flags, iter_flags;
`ifdef ALU_MC_DIV_EN
   logic             div0_q;
`endif

`ifdef ALU_MC_DIV_EN
   assign iter_op = (op == OP_MUL) || (op == OP_DIV);
`else
   assign iter_op = (op == OP_MUL);
`endif

   assign iter_start = in_valid && (state_q == IDLE) && iter_op;
   assign iter_last  = iter_busy && (cnt_q == CNT_W'(2));

   alu_mc_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk   (clk),
      .rst   (rst),
      .start (iter_start),
`ifdef ALU_MC_DIV_EN
      .is_div(op == OP_DIV),
`endif
      .last  (iter_last),
      .a     (a),
      .b     (b),
      .busy  (iter_busy),
      .done  (iter_done),
      .acc   (iter_acc)
   );

   // Single-cycle ops and their flags, computed from the request operands
   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sum    = '0;
      case (op)
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            sc_res = sum[MSB:0];
            sc_c   = sum[WIDTH];
            sc_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            // Carry out of a + ~b + 1 is the no-borrow flag
            sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            sc_res = sum[MSB:0];
            sc_c   = sum[WIDTH];
            sc_v   = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: sc_res = '0;
      endcase
      sc_flags        = '0;
      sc_flags[FLG_N] = sc_res[MSB];
      sc_flags[FLG_Z] = (sc_res == '0);
      sc_flags[FLG_C] = sc_c;
      sc_flags[FLG_V] = sc_v;
   end

   // Flags for a completed multiply/divide; only divide-by-zero sets V
   always_comb begin
      iter_flags        = '0;
      iter_flags[FLG_N] = iter_acc[MSB];
      iter_flags[FLG_Z] = (iter_acc == '0);
`ifdef ALU_MC_DIV_EN
      iter_flags[FLG_V] = div0_q;
`endif
   end

   // FSM, iteration counter and the registered result/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
`ifdef ALU_MC_DIV_EN
         div0_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (iter_op) begin
                     cnt_q   <= CNT_W'(WIDTH);
                     state_q <= ITER;
                  end else begin
                     result_q <= sc_res;
                     flags_q  <= sc_flags;
                     state_q  <= DONE;
                  end
`ifdef ALU_MC_DIV_EN
                  div0_q <= (op == OP_DIV) && (b == '0);
`endif
               end
            end
            ITER: begin
               cnt_q <= cnt_q - CNT_W'(1);
               // iter_done coincides with the counter stepping 1 -> 0
               if (iter_done) begin
                  result_q <= iter_acc;
                  flags_q  <= iter_flags;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven and scoreboarded checks for alu_mc (WIDTH=32).
module tb_alu_mc;
   import alu_mc_pkg::*;

   localparam int unsigned WIDTH    = 32;
   localparam int          MAX_WAIT = 100;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a, b, result;
   logic [3:0]       flags;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   alu_mc #(
      .WIDTH(WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .flags    (flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
      end
   endtask

   // Reference behaviour written from the arithmetic definitions
   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
      exp_t        e;
      longint      sr;
      logic [32:0] s;
      logic        c, v;
      c     = 1'b0;
      v     = 1'b0;
      sr    = 0;
      e.res = '0;
      case (o)
         3'd0: begin
            s     = {1'b0, x} + {1'b0, y};
            e.res = s[31:0];
            c     = s[32];
            sr    = longint'($signed(x)) + longint'($signed(y));
            v     = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd1: begin
            e.res = x - y;
            c     = (x >= y);
            sr    = longint'($signed(x)) - longint'($signed(y));
            v     = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd2: e.res = x & y;
         3'd3: e.res = x | y;
         3'd4: e.res = x ^ y;
         3'd5: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd6: e.res = x * y;
         default: begin
`ifdef ALU_MC_DIV_EN
            if (y == 32'd0) begin
               e.res = 32'hFFFF_FFFF;
               v     = 1'b1;
            end else begin
               e.res = x / y;
            end
`else
            e.res = 32'd0;
`endif
         end
      endcase
      e.flg = {e.res[31], (e.res == 32'd0), c, v};
      return e;
   endfunction

   function automatic int lat_of(input logic [2:0] o);
`ifdef ALU_MC_DIV_EN
      if (o == 3'd6 || o == 3'd7) return WIDTH + 1;
`else
      if (o == 3'd6) return WIDTH + 1;
`endif
      return 1;
   endfunction

   // Present a request, wait (bounded) for the accept edge, record the expectation
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input exp_t e);
      int n;
      n        = 0;
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      while (!in_ready && n < MAX_WAIT) begin
         tick();
         n++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called just after the accept edge; latency counts edges from that edge
   task automatic wait_result(input string name, input int exp_lat);
      int   lat;
      exp_t e;
      lat = 1;
      while (!out_valid && lat < MAX_WAIT) begin
         tick();
         lat++;
      end
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb: got empty scoreboard, want one pending result", name);
      end else begin
         e = sb.pop_front();
         check({name, "_res"}, result, e.res);
         check({name, "_flags"}, 32'(flags), 32'(e.flg));
      end
   endtask

   initial begin
      exp_t e0;
      int   n_valid;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 3'd0;
      a         = '0;
      b         = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", 32'(flags), 32'd0);

      // {op, a, b, result, {N,Z,C,V}, latency}
      vecs.push_back('{OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 1});
      vecs.push_back('{OP_SUB, 32'd5, 32'd5, 32'd0, 4'b0110, 1});
      vecs.push_back('{OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'd1, 4'b0000, 1});
      vecs.push_back('{OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 4'b0000, 33});
      vecs.push_back('{OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'd0, 4'b0110, 1});
      vecs.push_back('{OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000, 1});
      vecs.push_back('{OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1});
      vecs.push_back('{OP_OR, 32'd0, 32'd0, 32'd0, 4'b0100, 1});
      vecs.push_back('{OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 4'b0000, 1});
      vecs.push_back('{OP_XOR, 32'h1234_5678, 32'h1234_5678, 32'd0, 4'b0100, 1});
      vecs.push_back('{OP_SLT, 32'h1, 32'hFFFF_FFFF, 32'd0, 4'b0100, 1});
      vecs.push_back('{OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 4'b0000, 1});
      vecs.push_back('{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 4'b0000, 33});
      vecs.push_back('{OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 4'b1000, 33});
      vecs.push_back('{OP_MUL, 32'd0, 32'd5, 32'd0, 4'b0100, 33});
`ifdef ALU_MC_DIV_EN
      vecs.push_back('{OP_DIV, 32'd100, 32'd7, 32'd14, 4'b0000, 33});
      vecs.push_back('{OP_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'b1001, 33});
`else
      vecs.push_back('{OP_DIV, 32'd100, 32'd7, 32'd0, 4'b0100, 1});
`endif
      vecs.push_back('{OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011, 1});

      for (int i = 0; i < vecs.size(); i++) begin
         exp_t e;
         e.res = vecs[i].res;
         e.flg = vecs[i].flg;
         issue(vecs[i].op, vecs[i].a, vecs[i].b, e);
         wait_result($sformatf("vec%0d", i), vecs[i].lat);
         tick();
         check($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
      end
      // Flags survive into IDLE after the handshake
      check("flags_hold_idle", 32'(flags), 32'(vecs[vecs.size()-1].flg));

      // Backpressure: result held, second request ignored until release
      out_ready = 1'b0;
      e0.res    = 32'd6;
      e0.flg    = 4'b0010;
      issue(OP_SUB, 32'd9, 32'd3, e0);
      check("bp_valid", 32'(out_valid), 32'd1);
      op       = OP_XOR;
      a        = 32'h0000_00F0;
      b        = 32'h0000_000F;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp_res", result, 32'd6);
         check("bp_flags", 32'(flags), 32'b0010);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      e0 = sb.pop_front();
      check("bp_sb_res", result, e0.res);
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      sb.push_back(model(OP_XOR, 32'h0000_00F0, 32'h0000_000F));
      tick();
      in_valid = 1'b0;
      wait_result("bp_second", 1);
      tick();

      // Random operations against the reference model
      for (int r = 0; r < 12; r++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (r % 4 == 3) ? 32'($urandom_range(0, 300)) : $urandom;
         issue(ro, ra, rb, model(ro, ra, rb));
         wait_result($sformatf("rnd%0d", r), lat_of(ro));
         tick();
      end

      // Leave nonzero result/flags behind, then reset in the middle of a multiply
      issue(OP_SUB, 32'd3, 32'd5, model(OP_SUB, 32'd3, 32'd5));
      wait_result("pre_rst", 1);
      tick();
      issue(OP_MUL, 32'h1234, 32'h5678, model(OP_MUL, 32'h1234, 32'h5678));
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_flags", 32'(flags), 32'd0);
      check("rst_mid_result", result, 32'd0);
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      n_valid = 0;
      repeat (40) begin
         tick();
         if (out_valid) n_valid++;
      end
      check("rst_mid_no_emit", 32'(n_valid), 32'd0);

      issue(OP_ADD, 32'd2, 32'd2, model(OP_ADD, 32'd2, 32'd2));
      wait_result("post_rst", 1);
      tick();

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
